// File: rtl/rvfi_step_scheduler.sv
// Orders RVFI retirements into a single step-request stream for the reference model,
// pushing a mip update ahead of the first instruction of each interrupt handler.
module rvfi_step_scheduler #(
  parameter int unsigned NRET  = 2,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NRET-1:0]            rvfi_valid_i,
  input  logic [NRET*64-1:0]         rvfi_order_i,
  input  logic [NRET*XLEN-1:0]       rvfi_pc_i,
  input  logic [NRET-1:0]            rvfi_intr_i,
  input  logic [31:0]                irq_i,
  output logic                       step_valid_o,
  input  logic                       step_ready_i,
  output logic [63:0]                step_order_o,
  output logic [XLEN-1:0]            step_pc_o,
  output logic                       mip_valid_o,
  input  logic                       mip_ready_i,
  output logic [31:0]                mip_o,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count_o,
  output logic                       overflow_o,
  output logic                       order_err_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [63:0]     order;
    logic [XLEN-1:0] pc;
    logic            intr;
    logic [31:0]     irq;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_MIP, S_STEP} state_e;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      exp_order_q, exp_order_d;
  state_e           state_q;
  logic             step_valid_q, mip_valid_q, overflow_q, order_err_q;
  logic [63:0]      step_order_q;
  logic [XLEN-1:0]  step_pc_q;
  logic [31:0]      mip_q;

  entry_t           lane_entry [NRET];
  logic [CNT_W-1:0] lane_slot  [NRET];
  logic [NRET-1:0]  lane_acc;
  logic [CNT_W-1:0] free_c, n_acc_c;
  logic             drop_c, err_c, pop_c;
  logic             first_vld_c, head_vld_c, next_vld_c;
  entry_t           first_entry_c, head_c, next_c;

  // Pack valid lanes into free slots and run the order-continuity check in lane order.
  always_comb begin
    free_c        = CNT_W'(DEPTH) - count_q;
    n_acc_c       = '0;
    lane_acc      = '0;
    drop_c        = 1'b0;
    err_c         = 1'b0;
    exp_order_d   = exp_order_q;
    first_vld_c   = 1'b0;
    first_entry_c = '0;
    for (int l = 0; l < int'(NRET); l++) begin
      lane_entry[l].order = rvfi_order_i[l*64 +: 64];
      lane_entry[l].pc    = rvfi_pc_i[l*XLEN +: XLEN];
      lane_entry[l].intr  = rvfi_intr_i[l];
      lane_entry[l].irq   = irq_i;
      lane_slot[l]        = n_acc_c;
      if (rvfi_valid_i[l]) begin
        if (n_acc_c < free_c) begin
          lane_acc[l] = 1'b1;
          if (!first_vld_c) begin
            first_vld_c   = 1'b1;
            first_entry_c = lane_entry[l];
          end
          if (lane_entry[l].order != exp_order_d) err_c = 1'b1;
          exp_order_d = lane_entry[l].order + 64'd1;
          n_acc_c     = n_acc_c + CNT_W'(1);
        end else begin
          drop_c = 1'b1;
        end
      end
    end
  end

  // Head views include same-cycle arrivals so an empty FIFO still dispatches next cycle.
  always_comb begin
    pop_c      = (state_q == S_STEP) && step_ready_i;
    count_d    = count_q + n_acc_c - CNT_W'(pop_c);
    head_vld_c = (count_q != '0) || first_vld_c;
    head_c     = (count_q != '0) ? mem_q[rd_ptr_q] : first_entry_c;
    next_vld_c = (count_q > CNT_W'(1)) || first_vld_c;
    next_c     = (count_q > CNT_W'(1)) ? mem_q[rd_ptr_q + PTR_W'(1)] : first_entry_c;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      exp_order_q  <= '0;
      overflow_q   <= 1'b0;
      order_err_q  <= 1'b0;
      state_q      <= S_IDLE;
      step_valid_q <= 1'b0;
      mip_valid_q  <= 1'b0;
      step_order_q <= '0;
      step_pc_q    <= '0;
      mip_q        <= '0;
    end else begin
      for (int l = 0; l < int'(NRET); l++) begin
        if (lane_acc[l]) mem_q[wr_ptr_q + PTR_W'(lane_slot[l])] <= lane_entry[l];
      end
      wr_ptr_q    <= wr_ptr_q + PTR_W'(n_acc_c);
      rd_ptr_q    <= rd_ptr_q + PTR_W'(pop_c);
      count_q     <= count_d;
      exp_order_q <= exp_order_d;
      overflow_q  <= overflow_q | drop_c;
      order_err_q <= order_err_q | err_c;

      case (state_q)
        S_IDLE: begin
          if (head_vld_c) begin
            step_order_q <= head_c.order;
            step_pc_q    <= head_c.pc;
            mip_q        <= head_c.irq;
            if (head_c.intr) begin
              mip_valid_q <= 1'b1;
              state_q     <= S_MIP;
            end else begin
              step_valid_q <= 1'b1;
              state_q      <= S_STEP;
            end
          end
        end
        S_MIP: begin
          if (mip_ready_i) begin
            mip_valid_q  <= 1'b0;
            step_valid_q <= 1'b1;
            state_q      <= S_STEP;
          end
        end
        S_STEP: begin
          if (step_ready_i) begin
            if (next_vld_c) begin
              step_order_q <= next_c.order;
              step_pc_q    <= next_c.pc;
              mip_q        <= next_c.irq;
              if (next_c.intr) begin
                step_valid_q <= 1'b0;
                mip_valid_q  <= 1'b1;
                state_q      <= S_MIP;
              end
            end else begin
              step_valid_q <= 1'b0;
              state_q      <= S_IDLE;
            end
          end
        end
        default: begin
          step_valid_q <= 1'b0;
          mip_valid_q  <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign step_valid_o = step_valid_q;
  assign step_order_o = step_order_q;
  assign step_pc_o    = step_pc_q;
  assign mip_valid_o  = mip_valid_q;
  assign mip_o        = mip_q;
  assign fifo_count_o = count_q;
  assign overflow_o   = overflow_q;
  assign order_err_o  = order_err_q;

endmodule

// File: tb/tb_rvfi_step_scheduler.sv
// Directed bench for rvfi_step_scheduler with NRET=2, XLEN=32, DEPTH=8.
module tb_rvfi_step_scheduler;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [1:0]   rvfi_valid_i;
  logic [127:0] rvfi_order_i;
  logic [63:0]  rvfi_pc_i;
  logic [1:0]   rvfi_intr_i;
  logic [31:0]  irq_i;
  logic         step_valid_o, step_ready_i;
  logic [63:0]  step_order_o;
  logic [31:0]  step_pc_o;
  logic         mip_valid_o, mip_ready_i;
  logic [31:0]  mip_o;
  logic [3:0]   fifo_count_o;
  logic         overflow_o, order_err_o;

  int n_cmp = 0;
  int n_bad = 0;

  rvfi_step_scheduler #(.NRET(2), .XLEN(32), .DEPTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rvfi_valid_i(rvfi_valid_i), .rvfi_order_i(rvfi_order_i), .rvfi_pc_i(rvfi_pc_i),
    .rvfi_intr_i(rvfi_intr_i), .irq_i(irq_i),
    .step_valid_o(step_valid_o), .step_ready_i(step_ready_i),
    .step_order_o(step_order_o), .step_pc_o(step_pc_o),
    .mip_valid_o(mip_valid_o), .mip_ready_i(mip_ready_i), .mip_o(mip_o),
    .fifo_count_o(fifo_count_o), .overflow_o(overflow_o), .order_err_o(order_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Lane 0 pc = 0x1000+order, lane 1 pc = 0x2000+order.
  task automatic drive(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                       input logic [1:0] intr);
    rvfi_valid_i = v;
    rvfi_order_i = {o1, o0};
    rvfi_pc_i    = {32'h2000 + o1[31:0], 32'h1000 + o0[31:0]};
    rvfi_intr_i  = intr;
  endtask

  task automatic do_reset();
    drive(2'b00, 64'd0, 64'd0, 2'b00);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    step_ready_i = 1'b0; mip_ready_i = 1'b0; irq_i = '0;
    do_reset();
    n_cmp++; if (step_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_step_valid got %b want 0", step_valid_o); end
    n_cmp++; if (mip_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_mip_valid got %b want 0", mip_valid_o); end
    n_cmp++; if (fifo_count_o !== 4'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", fifo_count_o); end
    n_cmp++; if (overflow_o !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b want 0", overflow_o); end
    n_cmp++; if (order_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_order_err got %b want 0", order_err_o); end
  endtask

  task automatic test_in_order();
    do_reset();
    step_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(2'b01, 64'(k), 64'd0, 2'b00);
      tick();
      n_cmp++; if (step_valid_o !== 1'b1) begin n_bad++; $display("FAIL inorder_valid[%0d] got %b want 1", k, step_valid_o); end
      n_cmp++; if (step_order_o !== 64'(k)) begin n_bad++; $display("FAIL inorder_order[%0d] got %0d want %0d", k, step_order_o, k); end
      n_cmp++; if (step_pc_o !== 32'h1000 + 32'(k)) begin n_bad++; $display("FAIL inorder_pc[%0d] got %h want %h", k, step_pc_o, 32'h1000 + 32'(k)); end
      n_cmp++; if (fifo_count_o !== 4'd1) begin n_bad++; $display("FAIL inorder_count[%0d] got %0d want 1", k, fifo_count_o); end
    end
    drive(2'b00, 64'd0, 64'd0, 2'b00);
    tick();
    n_cmp++; if (step_valid_o !== 1'b0) begin n_bad++; $display("FAIL inorder_drain_valid got %b want 0", step_valid_o); end
    n_cmp++; if (fifo_count_o !== 4'd0) begin n_bad++; $display("FAIL inorder_drain_count got %0d want 0", fifo_count_o); end
    n_cmp++; if ({overflow_o, order_err_o} !== 2'b00) begin n_bad++; $display("FAIL inorder_flags got %b want 00", {overflow_o, order_err_o}); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(2'b01, 64'(k), 64'd0, 2'b00);
      tick();
    end
    drive(2'b00, 64'd0, 64'd0, 2'b00);
    tick();
    n_cmp++; if (fifo_count_o !== 4'd0) begin n_bad++; $display("FAIL b2b_seed_count got %0d want 0", fifo_count_o); end
    step_ready_i = 1'b0;
    drive(2'b11, 64'd5, 64'd6, 2'b00);
    tick();
    drive(2'b00, 64'd0, 64'd0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (step_valid_o !== 1'b1) begin n_bad++; $display("FAIL b2b_hold_valid[%0d] got %b want 1", i, step_valid_o); end
      n_cmp++; if (step_order_o !== 64'd5) begin n_bad++; $display("FAIL b2b_hold_order[%0d] got %0d want 5", i, step_order_o); end
      n_cmp++; if (fifo_count_o !== 4'd2) begin n_bad++; $display("FAIL b2b_hold_count[%0d] got %0d want 2", i, fifo_count_o); end
      tick();
    end
    step_ready_i = 1'b1;
    tick();
    n_cmp++; if (step_valid_o !== 1'b1) begin n_bad++; $display("FAIL b2b_second_valid got %b want 1", step_valid_o); end
    n_cmp++; if (step_order_o !== 64'd6) begin n_bad++; $display("FAIL b2b_second_order got %0d want 6", step_order_o); end
    n_cmp++; if (step_pc_o !== 32'h2006) begin n_bad++; $display("FAIL b2b_second_pc got %h want 00002006", step_pc_o); end
    n_cmp++; if (fifo_count_o !== 4'd1) begin n_bad++; $display("FAIL b2b_second_count got %0d want 1", fifo_count_o); end
    tick();
    n_cmp++; if (step_valid_o !== 1'b0) begin n_bad++; $display("FAIL b2b_end_valid got %b want 0", step_valid_o); end
    n_cmp++; if (order_err_o !== 1'b0) begin n_bad++; $display("FAIL b2b_order_err got %b want 0", order_err_o); end
  endtask

  task automatic test_interrupt();
    do_reset();
    step_ready_i = 1'b1; mip_ready_i = 1'b0;
    irq_i = 32'h0000_0800;
    drive(2'b01, 64'd0, 64'd0, 2'b01);
    tick();
    drive(2'b00, 64'd0, 64'd0, 2'b00);
    irq_i = 32'h0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (mip_valid_o !== 1'b1) begin n_bad++; $display("FAIL intr_mip_valid[%0d] got %b want 1", i, mip_valid_o); end
      n_cmp++; if (mip_o !== 32'h0000_0800) begin n_bad++; $display("FAIL intr_mip_value[%0d] got %h want 00000800", i, mip_o); end
      n_cmp++; if (step_valid_o !== 1'b0) begin n_bad++; $display("FAIL intr_step_early[%0d] got %b want 0", i, step_valid_o); end
      tick();
    end
    mip_ready_i = 1'b1;
    tick();
    mip_ready_i = 1'b0;
    n_cmp++; if (step_valid_o !== 1'b1) begin n_bad++; $display("FAIL intr_step_valid got %b want 1", step_valid_o); end
    n_cmp++; if (mip_valid_o !== 1'b0) begin n_bad++; $display("FAIL intr_mip_overlap got %b want 0", mip_valid_o); end
    n_cmp++; if (step_order_o !== 64'd0) begin n_bad++; $display("FAIL intr_step_order got %0d want 0", step_order_o); end
    tick();
    n_cmp++; if ({step_valid_o, mip_valid_o} !== 2'b00) begin n_bad++; $display("FAIL intr_end_valids got %b want 00", {step_valid_o, mip_valid_o}); end
    n_cmp++; if (fifo_count_o !== 4'd0) begin n_bad++; $display("FAIL intr_end_count got %0d want 0", fifo_count_o); end
  endtask

  task automatic test_overflow();
    do_reset();
    step_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 64'(2*k), 64'(2*k+1), 2'b00);
      tick();
    end
    n_cmp++; if (fifo_count_o !== 4'd8) begin n_bad++; $display("FAIL ovf_full_count got %0d want 8", fifo_count_o); end
    n_cmp++; if (overflow_o !== 1'b0) begin n_bad++; $display("FAIL ovf_full_flag got %b want 0", overflow_o); end
    n_cmp++; if (step_order_o !== 64'd0) begin n_bad++; $display("FAIL ovf_full_head got %0d want 0", step_order_o); end
    step_ready_i = 1'b1;
    drive(2'b11, 64'd8, 64'd9, 2'b00);
    tick();
    drive(2'b00, 64'd0, 64'd0, 2'b00);
    step_ready_i = 1'b0;
    n_cmp++; if (fifo_count_o !== 4'd7) begin n_bad++; $display("FAIL ovf_count got %0d want 7", fifo_count_o); end
    n_cmp++; if (overflow_o !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", overflow_o); end
    n_cmp++; if (step_order_o !== 64'd1) begin n_bad++; $display("FAIL ovf_next_head got %0d want 1", step_order_o); end
    n_cmp++; if (order_err_o !== 1'b0) begin n_bad++; $display("FAIL ovf_order_err got %b want 0", order_err_o); end
    tick();
    n_cmp++; if (overflow_o !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", overflow_o); end
    n_cmp++; if (fifo_count_o !== 4'd7) begin n_bad++; $display("FAIL ovf_hold_count got %0d want 7", fifo_count_o); end
  endtask

  task automatic test_order_err();
    logic [63:0] seq [4];
    seq[0] = 64'd0; seq[1] = 64'd1; seq[2] = 64'd3; seq[3] = 64'd4;
    do_reset();
    step_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(2'b01, seq[k], 64'd0, 2'b00);
      tick();
      n_cmp++; if (step_order_o !== seq[k] || step_valid_o !== 1'b1) begin n_bad++; $display("FAIL oerr_step[%0d] got %0d/%b want %0d/1", k, step_order_o, step_valid_o, seq[k]); end
      n_cmp++; if (order_err_o !== (k >= 2)) begin n_bad++; $display("FAIL oerr_flag[%0d] got %b want %b", k, order_err_o, k >= 2); end
    end
    drive(2'b00, 64'd0, 64'd0, 2'b00);
    tick();
    n_cmp++; if (step_valid_o !== 1'b0) begin n_bad++; $display("FAIL oerr_drain got %b want 0", step_valid_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step_ready_i = 1'b0;
    drive(2'b11, 64'd0, 64'd1, 2'b00);
    tick();
    drive(2'b00, 64'd0, 64'd0, 2'b00);
    n_cmp++; if (step_valid_o !== 1'b1 || fifo_count_o !== 4'd2) begin n_bad++; $display("FAIL rmid_pre got %b/%0d want 1/2", step_valid_o, fifo_count_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_cmp++; if ({step_valid_o, mip_valid_o} !== 2'b00) begin n_bad++; $display("FAIL rmid_valids got %b want 00", {step_valid_o, mip_valid_o}); end
    n_cmp++; if (fifo_count_o !== 4'd0) begin n_bad++; $display("FAIL rmid_count got %0d want 0", fifo_count_o); end
    n_cmp++; if (step_order_o !== 64'd0 || step_pc_o !== 32'd0 || mip_o !== 32'd0) begin n_bad++; $display("FAIL rmid_payload got %0d/%h/%h want 0/0/0", step_order_o, step_pc_o, mip_o); end
    step_ready_i = 1'b1;
    drive(2'b01, 64'd0, 64'd0, 2'b00);
    tick();
    drive(2'b00, 64'd0, 64'd0, 2'b00);
    n_cmp++; if (step_valid_o !== 1'b1 || step_order_o !== 64'd0) begin n_bad++; $display("FAIL rmid_restart got %b/%0d want 1/0", step_valid_o, step_order_o); end
    n_cmp++; if (order_err_o !== 1'b0) begin n_bad++; $display("FAIL rmid_order_err got %b want 0", order_err_o); end
    tick();
    n_cmp++; if (step_valid_o !== 1'b0 || fifo_count_o !== 4'd0) begin n_bad++; $display("FAIL rmid_end got %b/%0d want 0/0", step_valid_o, fifo_count_o); end
  endtask

  initial begin
    rst_i = 1'b0;
    step_ready_i = 1'b0;
    mip_ready_i = 1'b0;
    irq_i = '0;
    drive(2'b00, 64'd0, 64'd0, 2'b00);
    test_reset();
    test_in_order();
    test_back_to_back();
    test_interrupt();
    test_overflow();
    test_order_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rvfi_step_scheduler.md
# rvfi_step_scheduler

Serializes instructions retired by the core on its RVFI ports into a single ordered stream of step requests for the reference-model stepper, so the ISS advances exactly one instruction per retirement. It also sequences interrupt delivery: an interrupt's mip value is pushed to the reference model before the first trap-handler instruction is stepped. It sits between the core's RVFI outputs and the DPI-side stepper/comparator in the verification environment.

## Interface

- NRET, 2, retirement lanes per cycle (1..4)
- XLEN, 32, PC width in bits
- DEPTH, 8, buffer entries (power of two, >= NRET)

- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- rvfi_valid_i  in  NRET  per-lane retirement valid
- rvfi_order_i  in  NRET*64  per-lane instruction order (lane 0 in LSBs)
- rvfi_pc_i  in  NRET*XLEN  per-lane PC
- rvfi_intr_i  in  NRET  lane is the first instruction of an interrupt handler
- irq_i  in  32  current interrupt-pending vector (mip image)
- step_valid_o  out  1  step request valid
- step_ready_i  in  1  stepper accepts request
- step_order_o  out  64  order of the instruction to step
- step_pc_o  out  XLEN  expected PC of that instruction
- mip_valid_o  out  1  mip update request valid
- mip_ready_i  in  1  stepper accepts mip update
- mip_o  out  32  mip value to apply
- fifo_count_o  out  $clog2(DEPTH+1)  current occupancy
- overflow_o  out  1  sticky: a retirement was dropped
- order_err_o  out  1  sticky: order discontinuity detected

## Operation

- Each entry stores {order, pc, intr, irq snapshot}. The irq snapshot is irq_i sampled in the enqueue cycle.
- Enqueue: valid lanes are packed in ascending lane order (lane 0 first), skipping invalid lanes, and written in that sequence.
- Free space = DEPTH - fifo_count_o before this cycle's pop. A same-cycle pop does not create space.
- Lanes beyond the free space are dropped and overflow_o is set. The lanes that fit are still written.
- Order check, per accepted entry in packed sequence:
  - The entry's order must equal expected_order, otherwise order_err_o is set.
  - expected_order then becomes entry order + 1, whether or not it matched.
  - expected_order resets to 0.
  - Dropped lanes do not update expected_order.
- Dispatch FSM, states IDLE, MIP, STEP:
  - IDLE: if the FIFO is non-empty, go to MIP when the head has intr=1, else go to STEP. On entry, load the output registers from the head.
  - MIP: hold mip_valid_o=1 and mip_o = head snapshot. On mip_valid_o && mip_ready_i, go to STEP with step_valid_o=1 the following cycle.
  - STEP: hold step_valid_o=1 and step_order_o/step_pc_o from the head. On handshake, pop the head.
    - If the new head exists with intr=0, stay in STEP and present it the next cycle (back-to-back).
    - If the new head exists with intr=1, go to MIP.
    - If the FIFO is empty, go to IDLE.
- Valid/ready rules:
  - Once asserted, a valid and its payload stay stable until the handshake.
  - mip_valid_o and step_valid_o are never high in the same cycle.
  - Each intr entry gets exactly one mip update.
- Pointers wrap modulo DEPTH. fifo_count_o = count after this cycle's enqueue and pop.
- Sticky flags clear only on reset.

## Timing

- Reset:
  - The rising edge with rst_i=1 clears the FIFO, expected_order and the sticky flags, and forces IDLE.
  - All outputs are 0 in the following cycle, including mid-handshake (in-flight requests are abandoned).
- Latency:
  - Retirement sampled at edge N gives step_valid_o=1 in cycle N+1 (intr=0).
  - For intr=1, mip_valid_o=1 in cycle N+1 and step_valid_o=1 the cycle after the mip handshake.
- Throughput: 1 step per cycle with step_ready_i held high and no intr entries. Each intr entry costs one extra cycle minimum.
- fifo_count_o, overflow_o and order_err_o update one cycle after the triggering edge (registered).

## Test plan

- Reset, then retire orders 0,1,2 on lane 0 in consecutive cycles with step_ready_i=1. Required: step_valid_o in cycles 1,2,3 with order 0,1,2, no flags, count back to 0.
- NRET=2, lanes 0/1 carry orders 5/6 with expected_order pre-seeded to 5 via prior traffic, step_ready_i=0 for 4 cycles. Required: count=2, order 5 held stable, then 5 and 6 issue back-to-back after ready rises.
- intr=1 retirement with irq_i=0x00000800. Required: mip_valid_o with mip_o=0x800, then step_valid_o. Delaying mip_ready_i by 3 cycles delays the step by 3 cycles, and the two valids never overlap.
- Fill DEPTH=8 with ready=0, then retire 2 more while ready=1 pops one. Required: both dropped, overflow_o=1 and sticky, count stays 7 after the pop.
- Retire orders 0,1,3. Required: order_err_o=1 after the third entry. All three are still stepped. A following order 4 raises no new error.
- Assert rst_i while step_valid_o=1 with entries buffered. Required: next cycle all outputs 0 and count 0. A new retirement of order 0 then issues normally.
